uart_receiver_cfg: RTL and testbench
====================================

Name: uart_receiver_cfg

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It provides configurable data width, parity and stop bits, and samples each bit at mid-bit using a start-edge-aligned baud counter. Line errors (framing, parity) and overrun are reported explicitly. The received word is handed to the consumer through a valid/ready holding register, so the controller can stall without losing the next frame.

Parameters:
CLKFRQ  100000000  system clock frequency, Hz
BAUDRATE  9600  line bit rate, bits/s
DATA_BITS  8  payload bits per frame; legal values 5..8
PARITY  0  0 = none, 1 = odd, 2 = even
STOP_BITS  1  1 or 2 stop bits

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
rx  in  1  asynchronous serial line; idles high
en  in  1  receive enable; frames start only while high
data  out  DATA_BITS  received payload; LSB was first on the line
valid  out  1  data, parity_err and frame_err hold a complete frame
ready  in  1  consumer accepts the word when valid && ready
parity_err  out  1  parity mismatch for the word in data; 0 when PARITY=0
frame_err  out  1  a stop bit sampled low for the word in data
overrun  out  1  sticky; a frame was dropped because the holding register was full
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Constants: CPB = CLKFRQ/BAUDRATE; HALF = CPB/2. The baud counter is 16 bits; CPB must be at most 65535 and at least 4.
- Synchroniser: rx passes through two flops, giving rx_s. All decisions use rx_s. Latency rx -> rx_s is 2 clk.
- Reset (reset==0 at a clk edge), from any state, including mid-frame:
  - FSM goes to IDLE; counters clear; any partial frame is discarded.
  - Synchroniser flops reset to 1.
  - Outputs: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- FSM states and transitions:
  - IDLE: when en && rx_s==0, load counter=HALF-1 and go to START.
  - START: count down to 0, then re-check rx_s.
    - rx_s==1: glitch; return to IDLE. No output, no error.
    - rx_s==0: load counter=CPB-1, bit index=0, and go to DATA.
  - DATA: at each counter==0, shift rx_s into the word at the bit index and reload CPB-1.
    - After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit at counter==0.
    - Mismatch rules: odd parity errs when XOR(payload, pbit)==0; even parity errs when it equals 1.
  - STOP: sample STOP_BITS bits, one per CPB.
    - Any stop bit sampled 0 sets the frame's frame error.
    - After the last stop sample, go to DONE.
  - DONE: one cycle, then IDLE.
    - Holding register free (valid==0, or valid&&ready this cycle): load data and both error flags; valid=1.
    - Otherwise: drop the frame and set overrun=1.
- Sampling points: nominally 1.5*CPB, 2.5*CPB, ... clocks after the synchronised falling edge. The counter reloads exactly; there is no accumulated drift beyond integer truncation.
- Handshake:
  - valid stays high, and data/errors stay stable, until the cycle valid&&ready is seen; valid falls the following cycle.
  - A DONE in the same cycle as acceptance loads the new word; valid stays 1 continuously.
- overrun: cleared only by reset.
- en: sampled only in IDLE. Dropping en mid-frame does not abort the frame.
- The frame with a framing error is still delivered, with frame_err=1.
- busy: 1 in START, DATA, PARITY, STOP and DONE.
- Back-to-back frames: the FSM returns to IDLE after the last stop-bit sample, so a start bit arriving immediately afterwards is detected. The inter-frame gap may be 0.

Test Plan:
Use CLKFRQ=1000000, BAUDRATE=100000 (CPB=10) throughout.
- 8N1, ready=1: send 0xA5 -> valid pulses 1 clk with data=0xA5, both errors 0. valid rises 96..98 clk after the start edge at rx.
- PARITY=2, DATA_BITS=7: send 0x35 with pbit=0 -> data=0x35, parity_err=0. Repeat with pbit=1 -> data=0x35, parity_err=1.
- Stop bit driven 0 in 8N1 sending 0x3C -> data=0x3C, frame_err=1. The next frame 0x01 -> frame_err=0.
- rx low for 3 clk then high -> no valid; busy rises, then returns to 0 within HALF+3 clk.
- ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, overrun=1. Raising ready -> valid falls after 1 cycle; overrun stays 1.
- Assert reset low mid-DATA of 0x5A -> all outputs 0 next clk. The following full frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_receiver_cfg.sv
// UART receiver with configurable width, parity and stop bits, mid-bit sampling,
// line-error reporting and a valid/ready holding register for the received word.
`timescale 1ns/1ps

module uart_receiver_cfg #(
   parameter int CLKFRQ    = 100000000,
   parameter int BAUDRATE  = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 en,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   // state    | meaning
   // S_IDLE   | line idle, waiting for a low rx_s while en is high
   // S_START  | half-bit wait, then confirm the start bit is still low
   // S_DATA   | sample payload bits, LSB first, one per bit period
   // S_PARITY | sample the parity bit
   // S_STOP   | sample STOP_BITS stop bits
   // S_DONE   | hand the frame to the holding register or flag overrun

   localparam int          CPB       = CLKFRQ / BAUDRATE;
   localparam int          HALF      = CPB / 2;
   localparam logic [15:0] CPB_M1    = 16'(CPB - 1);
   localparam logic [15:0] HALF_M1   = 16'(HALF - 1);
   localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
   } state_t;

   state_t                 r_state;
   logic                   r_sync1, r_sync2;
   logic [15:0]            r_cnt;
   logic [2:0]             r_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_perr_f, r_ferr_f;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_valid, r_perr, r_ferr, r_overrun, r_busy;
   logic                   w_par_x, w_par_err;

   assign w_par_x   = (^r_shift) ^ r_sync2;
   assign w_par_err = (PARITY == 1) ? ~w_par_x : w_par_x;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_perr_f  <= 1'b0;
         r_ferr_f  <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         if (r_valid && ready) r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en && !r_sync2) begin
                  r_cnt   <= HALF_M1;
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (r_sync2) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt    <= CPB_M1;
                  r_idx    <= '0;
                  r_perr_f <= 1'b0;
                  r_ferr_f <= 1'b0;
                  r_state  <= S_DATA;
               end
            end
            S_DATA: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  // Right shift so the first (LSB) bit ends up at bit 0.
                  r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                  r_cnt   <= CPB_M1;
                  if (r_idx == LAST_DATA) begin
                     r_idx   <= '0;
                     r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_perr_f <= w_par_err;
                  r_cnt    <= CPB_M1;
                  r_state  <= S_STOP;
               end
            end
            S_STOP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  if (!r_sync2) r_ferr_f <= 1'b1;
                  r_cnt <= CPB_M1;
                  if (r_idx == LAST_STOP) r_state <= S_DONE;
                  else                    r_idx   <= r_idx + 3'd1;
               end
            end
            S_DONE: begin
               // A word accepted this cycle frees the register for the new one.
               if (!r_valid || ready) begin
                  r_data  <= r_shift;
                  r_perr  <= r_perr_f;
                  r_ferr  <= r_ferr_f;
                  r_valid <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data       = r_data;
   assign valid      = r_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Bench for uart_receiver_cfg: an 8N1 and a 7E2 instance driven by directed and
// random frames, checked every cycle against a frame-level queue model.
`timescale 1ns/1ps

module tb_uart_receiver_cfg;
   localparam int CLKFRQ = 1000000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLKFRQ / BAUD;
   localparam int HALF   = CPB / 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx0, en0, ready0, valid0, perr0, ferr0, ovr0, busy0;
   logic [7:0] data0;
   logic       rx1, en1, ready1, valid1, perr1, ferr1, ovr1, busy1;
   logic [6:0] data1;

   uart_receiver_cfg #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .DATA_BITS(8),
                       .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset(reset), .rx(rx0), .en(en0), .data(data0), .valid(valid0),
      .ready(ready0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0));

   uart_receiver_cfg #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .DATA_BITS(7),
                       .PARITY(2), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .reset(reset), .rx(rx1), .en(en1), .data(data1), .valid(valid1),
      .ready(ready1), .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1));

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      int         load;
      logic [7:0] d;
      bit         pe;
      bit         fe;
   } frame_t;

   frame_t     q[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   bit         chk_en = 1'b0;
   bit         rand_rdy = 1'b0;
   bit         mv[2], mo[2], mpe[2], mfe[2];
   logic [7:0] md[2];
   bit         m_rdy, m_free;
   int         rise_cyc[2], nrise[2], plen[2];
   logic [7:0] cap_d[2];
   logic       cap_pe[2], cap_fe[2];
   logic       pv[2] = '{1'b0, 1'b0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Frame-level model: each sent frame lands in the holding register on a known edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset) begin
         for (int id = 0; id < 2; id++) begin
            mv[id] = 1'b0;
            mo[id] = 1'b0;
         end
         q.delete();
      end else begin
         for (int id = 0; id < 2; id++) begin
            m_rdy  = (id == 0) ? ready0 : ready1;
            m_free = !mv[id] || m_rdy;
            if (mv[id] && m_rdy) mv[id] = 1'b0;
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].id == id && q[i].load == cyc) begin
                  if (m_free) begin
                     mv[id]  = 1'b1;
                     md[id]  = q[i].d;
                     mpe[id] = q[i].pe;
                     mfe[id] = q[i].fe;
                  end else begin
                     mo[id] = 1'b1;
                  end
                  q.delete(i);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid0", valid0, mv[0]);
         if (mv[0]) begin
            chk("data0", data0, md[0]);
            chk("perr0", perr0, mpe[0]);
            chk("ferr0", ferr0, mfe[0]);
         end
         chk("overrun0", ovr0, mo[0]);
         chk("valid1", valid1, mv[1]);
         if (mv[1]) begin
            chk("data1", {1'b0, data1}, md[1]);
            chk("perr1", perr1, mpe[1]);
            chk("ferr1", ferr1, mfe[1]);
         end
         chk("overrun1", ovr1, mo[1]);
      end
      if (valid0 && !pv[0]) begin
         rise_cyc[0] = cyc; cap_d[0] = data0; cap_pe[0] = perr0; cap_fe[0] = ferr0;
         nrise[0]++;
      end
      if (!valid0 && pv[0]) plen[0] = cyc - rise_cyc[0];
      if (valid1 && !pv[1]) begin
         rise_cyc[1] = cyc; cap_d[1] = {1'b0, data1}; cap_pe[1] = perr1; cap_fe[1] = ferr1;
         nrise[1]++;
      end
      if (!valid1 && pv[1]) plen[1] = cyc - rise_cyc[1];
      pv[0] = valid0;
      pv[1] = valid1;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            ready0 = ($urandom_range(0, 3) != 0);
            ready1 = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   task automatic drive_line(input int id, input logic [15:0] bits, input int n);
      for (int j = 0; j < n; j++) begin
         if (id == 0) rx0 = bits[j];
         else         rx1 = bits[j];
         tick(CPB);
      end
   endtask

   task automatic send_frame(input int id, input logic [7:0] d, input logic pbit,
                             input bit bad_stop, input bit expect_it);
      int          dw, par, sb, n;
      logic [15:0] bits;
      frame_t      f;
      dw = (id == 0) ? 8 : 7;
      par = (id == 0) ? 0 : 2;
      sb = (id == 0) ? 1 : 2;
      bits = '1;
      bits[0] = 1'b0;
      n = 1;
      for (int i = 0; i < dw; i++) begin bits[n] = d[i]; n++; end
      if (par != 0) begin bits[n] = pbit; n++; end
      for (int i = 0; i < sb; i++) begin bits[n] = !(bad_stop && i == 0); n++; end
      if (expect_it) begin
         f.id = id;
         // Last stop sample lands 3+HALF+CPB*(bits after start) edges after the line edge.
         f.load = cyc + 4 + HALF + CPB * (n - 1);
         f.d = d & 8'((1 << dw) - 1);
         f.fe = bad_stop;
         if (par == 2)      f.pe = (($countones(f.d) + int'(pbit)) % 2) == 1;
         else if (par == 1) f.pe = (($countones(f.d) + int'(pbit)) % 2) == 0;
         else               f.pe = 1'b0;
         q.push_back(f);
      end
      drive_line(id, bits, n);
      if (id == 0) rx0 = 1'b1;
      else         rx1 = 1'b1;
   endtask

   initial begin
      int          k0, n0, lat, gap, id;
      logic [7:0]  d;
      logic        pb;
      bit          bs;
      logic [15:0] b5a;

      reset = 1'b0; rx0 = 1'b1; rx1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
      ready0 = 1'b1; ready1 = 1'b1;
      tick(3);
      @(negedge clk);
      chk("rst_data0", data0, 8'h00);
      chk("rst_valid0", valid0, 1'b0);
      chk("rst_perr0", perr0, 1'b0);
      chk("rst_ferr0", ferr0, 1'b0);
      chk("rst_ovr0", ovr0, 1'b0);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_data1", {1'b0, data1}, 8'h00);
      chk("rst_valid1", valid1, 1'b0);
      tick(1);
      reset = 1'b1;
      chk_en = 1'b1;
      tick(5);

      // 8N1 0xA5 with ready held high
      k0 = cyc; n0 = nrise[0];
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      tick(3);
      lat = rise_cyc[0] - (k0 + 1);
      total++;
      if (lat < 96 || lat > 98) begin
         bad++;
         $display("FAIL a5_latency: got %0d want 96..98", lat);
      end
      chk("a5_count", nrise[0] - n0, 1);
      chk("a5_data", cap_d[0], 8'hA5);
      chk("a5_perr", cap_pe[0], 1'b0);
      chk("a5_ferr", cap_fe[0], 1'b0);
      chk("a5_width", plen[0], 1);
      chk("a5_idle", busy0, 1'b0);

      // 7E2 0x35: even number of ones, so pbit=0 is clean and pbit=1 errs
      send_frame(1, 8'h35, 1'b0, 1'b0, 1'b1);
      tick(3);
      chk("p0_data", cap_d[1], 8'h35);
      chk("p0_perr", cap_pe[1], 1'b0);
      send_frame(1, 8'h35, 1'b1, 1'b0, 1'b1);
      tick(3);
      chk("p1_data", cap_d[1], 8'h35);
      chk("p1_perr", cap_pe[1], 1'b1);
      chk("p1_ferr", cap_fe[1], 1'b0);

      // framing error, then a clean frame
      send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      tick(2 * CPB);
      chk("fe_data", cap_d[0], 8'h3C);
      chk("fe_ferr", cap_fe[0], 1'b1);
      send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
      tick(3);
      chk("fe_next_data", cap_d[0], 8'h01);
      chk("fe_next_ferr", cap_fe[0], 1'b0);

      // start glitch of 3 clocks
      n0 = nrise[0];
      rx0 = 1'b0;
      tick(3);
      rx0 = 1'b1;
      @(negedge clk);
      chk("glitch_busy_hi", busy0, 1'b1);
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_lo", busy0, 1'b0);
      tick(CPB);
      chk("glitch_no_valid", nrise[0] - n0, 0);

      // overrun with consumer stalled
      ready0 = 1'b0;
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      tick(3);
      chk("ovr_valid", valid0, 1'b1);
      chk("ovr_data", data0, 8'h11);
      chk("ovr_flag", ovr0, 1'b1);
      ready0 = 1'b1;
      tick(1);
      chk("ovr_valid_fell", valid0, 1'b0);
      chk("ovr_sticky", ovr0, 1'b1);

      // en low: frames are ignored
      en0 = 1'b0;
      n0 = nrise[0];
      send_frame(0, 8'h66, 1'b0, 1'b0, 1'b0);
      tick(3);
      chk("en_no_valid", nrise[0] - n0, 0);
      chk("en_no_busy", busy0, 1'b0);
      en0 = 1'b1;

      // reset in the middle of a frame while a word is held
      ready0 = 1'b0;
      send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
      tick(3);
      chk("pre_rst_data", data0, 8'h77);
      b5a = {7'h7F, 8'h5A, 1'b0};
      drive_line(0, b5a, 4);
      chk("mid_busy", busy0, 1'b1);
      rx0 = 1'b1;
      reset = 1'b0;
      tick(1);
      chk("mid_rst_data", data0, 8'h00);
      chk("mid_rst_valid", valid0, 1'b0);
      chk("mid_rst_perr", perr0, 1'b0);
      chk("mid_rst_ferr", ferr0, 1'b0);
      chk("mid_rst_ovr", ovr0, 1'b0);
      chk("mid_rst_busy", busy0, 1'b0);
      reset = 1'b1;
      tick(2 * CPB);
      ready0 = 1'b1;
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
      tick(3);
      chk("post_rst_data", cap_d[0], 8'h0F);
      chk("post_rst_ferr", cap_fe[0], 1'b0);

      // random frames on both lines with a randomly stalling consumer
      rand_rdy = 1'b1;
      for (int it = 0; it < 40; it++) begin
         id = $urandom_range(0, 1);
         d = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         bs = ($urandom_range(0, 5) == 0);
         send_frame(id, d, pb, bs, 1'b1);
         gap = $urandom_range(0, 25);
         if (bs) gap += 2 * CPB;
         tick(gap);
      end
      rand_rdy = 1'b0;
      ready0 = 1'b1;
      ready1 = 1'b1;
      tick(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      total++;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
